// File: rtl/alu_mov_pkg.sv
// Shared types for the MOV-class execution unit.
// Opcode/condition encodings and flag bit positions.
package alu_mov_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    OP_MOV   = 3'd0,
    OP_MVN   = 3'd1,
    OP_MOVZB = 3'd2,
    OP_MOVSB = 3'd3,
    OP_SWAPB = 3'd4,
    OP_CLR   = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  typedef enum logic [3:0] {
    CC_EQ   = 4'd0,
    CC_NE   = 4'd1,
    CC_CS   = 4'd2,
    CC_CC   = 4'd3,
    CC_MI   = 4'd4,
    CC_PL   = 4'd5,
    CC_VS   = 4'd6,
    CC_VC   = 4'd7,
    CC_GE   = 4'd8,
    CC_LT   = 4'd9,
    CC_GT   = 4'd10,
    CC_LE   = 4'd11,
    CC_NV12 = 4'd12,
    CC_NV13 = 4'd13,
    CC_AL   = 4'd14,
    CC_NV   = 4'd15
  } cond_e;

  function automatic logic op_legal(
    input logic [2:0] op
  );
    return op <= 3'(OP_CLR);
  endfunction

  function automatic logic [3:0] mk_flags(
    input logic z,
    input logic n
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_mov_unit_cond_eval.sv
// Condition-code evaluator for predicated MOV-class beats.
// Pure combinational: (cond, flags) -> pass.
module alu_mov_cond_eval
  import alu_mov_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic z;
  logic n;
  logic c;
  logic v;

  assign z = flags_i[FLAG_Z];
  assign n = flags_i[FLAG_N];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_e'(cond_i))
      CC_EQ:   pass_o = z;
      CC_NE:   pass_o = !z;
      CC_CS:   pass_o = c;
      CC_CC:   pass_o = !c;
      CC_MI:   pass_o = n;
      CC_PL:   pass_o = !n;
      CC_VS:   pass_o = v;
      CC_VC:   pass_o = !v;
      CC_GE:   pass_o = (n == v);
      CC_LT:   pass_o = (n != v);
      CC_GT:   pass_o = !z && (n == v);
      CC_LE:   pass_o = z || (n != v);
      CC_AL:   pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_mov_unit.sv
// Registered MOV-class unit with NZCV flags and valid/ready output stage.
// Define ALU_MOV_COND_EN to add the predicated in_cond port.
module alu_mov_unit
  import alu_mov_pkg::*;
#(
  parameter int         WIDTH     = 16,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_setf,
`ifdef ALU_MOV_COND_EN
  input  logic [3:0]       in_cond,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_we,
  output logic             out_illegal,
  output logic [3:0]       flags_q
);

  localparam int NB = WIDTH / 8;

  if ((WIDTH % 8) != 0 || WIDTH < 16) begin : g_bad_width
    $error("alu_mov_unit: WIDTH must be a multiple of 8 and >= 16");
  end

  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_result_q;
  logic [WIDTH-1:0] out_result_d;
  logic             out_we_q;
  logic             out_we_d;
  logic             out_illegal_q;
  logic             out_illegal_d;
  logic [3:0]       flags_d;

  logic             accept;
  logic             legal;
  logic             pass;
  logic             exec;
  logic [WIDTH-1:0] swp;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sel;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign legal    = op_legal(in_op);

`ifdef ALU_MOV_COND_EN
  alu_mov_cond_eval u_cond (
    .cond_i  (in_cond),
    .flags_i (flags_q),
    .pass_o  (pass)
  );
`else
  assign pass = 1'b1;
`endif

  assign exec = legal && pass;

  always_comb begin
    swp = '0;
    for (int i = 0; i < NB; i++) begin
      swp[i*8 +: 8] = in_a[(NB-1-i)*8 +: 8];
    end
  end

  always_comb begin
    res = '0;
    unique case (op_e'(in_op))
      OP_MOV:   res = in_a;
      OP_MVN:   res = ~in_a;
      OP_MOVZB: res = {{(WIDTH-8){1'b0}}, in_a[7:0]};
      OP_MOVSB: res = {{(WIDTH-8){in_a[7]}}, in_a[7:0]};
      OP_SWAPB: res = swp;
      default:  res = '0;
    endcase
  end

  // Squashed beats forward the operand; reserved ops always yield zero.
  always_comb begin
    if (!legal) begin
      sel = '0;
    end else if (!pass) begin
      sel = in_a;
    end else begin
      sel = res;
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_we_d      = out_we_q;
    out_illegal_d = out_illegal_q;
    flags_d       = flags_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_result_d  = sel;
      out_we_d      = exec;
      out_illegal_d = !legal;
      if (exec && in_setf) begin
        flags_d = mk_flags(res == '0, res[WIDTH-1]);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_we_q      <= 1'b0;
      out_illegal_q <= 1'b0;
      flags_q       <= FLAGS_RST;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_we_q      <= out_we_d;
      out_illegal_q <= out_illegal_d;
      flags_q       <= flags_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_we      = out_we_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_mov_unit.sv
// Directed bench for alu_mov_unit at WIDTH=16 and WIDTH=32.
// Cond checks are active when ALU_MOV_COND_EN is defined.
module tb_alu_mov_unit;
  import alu_mov_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic        in_setf;
  logic        out_ready;
`ifdef ALU_MOV_COND_EN
  logic [3:0]  in_cond;
`endif

  logic        rdy16, v16, we16, il16;
  logic [15:0] r16;
  logic [3:0]  f16;
  logic        rdy32, v32, we32, il32;
  logic [31:0] r32;
  logic [3:0]  f32;

  logic        sel32;
  logic        o_rdy, o_valid, o_we, o_ill;
  logic [31:0] o_result;
  logic [3:0]  o_flags;

  int ntests = 0;
  int nfail  = 0;
  int idx;
  int nrecv;

  always #5 clk = ~clk;

  alu_mov_unit #(.WIDTH(16), .FLAGS_RST(4'b0000)) dut16 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (rdy16),
    .in_op       (in_op),
    .in_a        (in_a[15:0]),
    .in_setf     (in_setf),
`ifdef ALU_MOV_COND_EN
    .in_cond     (in_cond),
`endif
    .out_valid   (v16),
    .out_ready   (out_ready),
    .out_result  (r16),
    .out_we      (we16),
    .out_illegal (il16),
    .flags_q     (f16)
  );

  alu_mov_unit #(.WIDTH(32), .FLAGS_RST(4'b0001)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (rdy32),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_setf     (in_setf),
`ifdef ALU_MOV_COND_EN
    .in_cond     (in_cond),
`endif
    .out_valid   (v32),
    .out_ready   (out_ready),
    .out_result  (r32),
    .out_we      (we32),
    .out_illegal (il32),
    .flags_q     (f32)
  );

  assign o_rdy    = sel32 ? rdy32 : rdy16;
  assign o_valid  = sel32 ? v32 : v16;
  assign o_we     = sel32 ? we32 : we16;
  assign o_ill    = sel32 ? il32 : il16;
  assign o_result = sel32 ? r32 : {16'h0000, r16};
  assign o_flags  = sel32 ? f32 : f16;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic beat(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic        setf
  );
    in_op    = op;
    in_a     = a;
    in_setf  = setf;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(
    input string       tag,
    input logic [31:0] res,
    input logic        we,
    input logic        ill,
    input logic [3:0]  fl
  );
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_res"},   o_result,     res);
    check({tag, "_we"},    32'(o_we),    32'(we));
    check({tag, "_ill"},   32'(o_ill),   32'(ill));
    check({tag, "_flags"}, 32'(o_flags), 32'(fl));
  endtask

  initial begin
    sel32     = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_setf   = 1'b0;
    out_ready = 1'b1;
`ifdef ALU_MOV_COND_EN
    in_cond   = CC_AL;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  32'(o_valid), 32'd0);
    check("rst_res",    o_result,     32'h0);
    check("rst_we",     32'(o_we),    32'd0);
    check("rst_ill",    32'(o_ill),   32'd0);
    check("rst_flags",  32'(o_flags), 32'h0);
    rst = 1'b0;

    beat(OP_MOV,   32'h8000, 1'b1); expect_out("mov",   32'h8000, 1, 0, 4'b0100);
    beat(OP_MOVSB, 32'h0080, 1'b1); expect_out("movsb", 32'hFF80, 1, 0, 4'b0100);
    beat(OP_MOVZB, 32'h12F0, 1'b0); expect_out("movzb", 32'h00F0, 1, 0, 4'b0100);
    beat(OP_SWAPB, 32'h1234, 1'b1); expect_out("swapb", 32'h3412, 1, 0, 4'b0000);
    beat(OP_MVN,   32'hFFFF, 1'b1); expect_out("mvn",   32'h0000, 1, 0, 4'b1000);
    beat(OP_RSV6,  32'h5555, 1'b1); expect_out("rsv6",  32'h0000, 0, 1, 4'b1000);
    beat(OP_MOV,   32'h00A5, 1'b0); expect_out("mov2",  32'h00A5, 1, 0, 4'b1000);

    @(posedge clk);
    #1;
    check("idle_valid", 32'(o_valid), 32'd0);
    check("idle_hold",  o_result,     32'h00A5);

`ifdef ALU_MOV_COND_EN
    beat(OP_CLR, 32'h1234, 1'b1); expect_out("clr", 32'h0, 1, 0, 4'b1000);
    in_cond = CC_NE;
    beat(OP_MOV, 32'h0005, 1'b1); expect_out("c_ne", 32'h5, 0, 0, 4'b1000);
    in_cond = CC_EQ;
    beat(OP_MOV, 32'h0005, 1'b1); expect_out("c_eq", 32'h5, 1, 0, 4'b0000);
    in_cond = CC_NV;
    beat(OP_RSV7, 32'h0009, 1'b0); expect_out("c_rsv", 32'h0, 0, 1, 4'b0000);
    in_cond = CC_AL;
`endif

    // Four back-to-back beats with a three-cycle downstream stall.
    idx   = 0;
    nrecv = 0;
    for (int c = 0; c < 30 && nrecv < 4; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (idx < 4);
      in_op     = OP_MOV;
      in_a      = 32'(idx + 1);
      in_setf   = 1'b0;
      #1;
      if (o_valid) check("strm_data", o_result, 32'(nrecv + 1));
      if (o_valid && !out_ready) check("strm_stall_rdy", 32'(o_rdy), 32'd0);
      if (o_valid && out_ready) nrecv++;
      if (in_valid && o_rdy) idx++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("strm_recv", 32'(nrecv), 32'd4);
    check("strm_sent", 32'(idx),   32'd4);

    // Reset while a beat is stalled at the output.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    beat(OP_MOV, 32'h8000, 1'b1);
    check("pre_rst_flags", 32'(o_flags), 32'b0100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("stall_rst_valid", 32'(o_valid), 32'd0);
    check("stall_rst_flags", 32'(o_flags), 32'h0);
    check("stall_rst_res",   o_result,     32'h0);

    // WIDTH=32 instance, FLAGS_RST=4'b0001.
    sel32 = 1'b1;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("w32_rst_valid", 32'(o_valid), 32'd0);
    check("w32_rst_flags", 32'(o_flags), 32'b0001);
    beat(OP_MOV,   32'h8000_0000, 1'b1);
    expect_out("w32_mov",   32'h8000_0000, 1, 0, 4'b0100);
    beat(OP_MOVSB, 32'h0000_0080, 1'b1);
    expect_out("w32_movsb", 32'hFFFF_FF80, 1, 0, 4'b0100);
    beat(OP_MOVZB, 32'h1234_56F0, 1'b1);
    expect_out("w32_movzb", 32'h0000_00F0, 1, 0, 4'b0000);
    beat(OP_SWAPB, 32'h1234_5678, 1'b1);
    expect_out("w32_swapb", 32'h7856_3412, 1, 0, 4'b0000);
    beat(OP_MVN,   32'hFFFF_FFFF, 1'b1);
    expect_out("w32_mvn",   32'h0000_0000, 1, 0, 4'b1000);
    beat(OP_RSV7,  32'h0000_0005, 1'b1);
    expect_out("w32_rsv7",  32'h0000_0000, 0, 1, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
